// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: opcode encoding and
// the width helper for the return-stack occupancy count.
package pc_pkg;

   localparam logic [2:0] OP_INC   = 3'd0;
   localparam logic [2:0] OP_GOTO  = 3'd1;
   localparam logic [2:0] OP_CALL  = 3'd2;
   localparam logic [2:0] OP_RET   = 3'd3;
   localparam logic [2:0] OP_SKIP  = 3'd4;
   localparam logic [2:0] OP_HOLD  = 3'd5;
   localparam logic [2:0] OP_LDPCL = 3'd6;
   localparam logic [2:0] OP_INC_B = 3'd7;

   // Level counts 0..DEPTH inclusive, so one bit wider than the pointer.
   function automatic int stack_level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hw_stack.sv
// Circular LIFO return stack with occupancy count and sticky fault flags.
// Push/pop update on the posedge they are asserted; pop data is combinational.
module hw_stack
   import pc_pkg::*;
#(
   parameter int W     = 13,
   parameter int DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_push,
   input  logic                               i_pop,
   input  logic [W-1:0]                       i_push_dat,
   input  logic                               i_clr_flags,
   output logic [W-1:0]                       o_pop_dat,
   output logic [stack_level_w(DEPTH)-1:0]    o_level,
   output logic                               o_overflow,
   output logic                               o_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = stack_level_w(DEPTH);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [LW-1:0] r_level;
   logic          r_overflow;
   logic          r_underflow;

   logic [PW-1:0] w_rd_ptr;
   logic          w_ovf_evt;
   logic          w_unf_evt;

   assign w_rd_ptr  = r_wp - PW'(1);
   assign w_ovf_evt = i_push && (r_level == FULL);
   assign w_unf_evt = i_pop && (r_level == '0);

   // Contents survive reset; only the pointer and count are cleared.
   always_ff @(posedge clk) begin
      if (reset && i_push) begin
         r_mem[r_wp] <= i_push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wp        <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_push) begin
            r_wp <= r_wp + PW'(1);
            if (!w_ovf_evt) begin
               r_level <= r_level + LW'(1);
            end
         end else if (i_pop) begin
            r_wp <= w_rd_ptr;
            if (!w_unf_evt) begin
               r_level <= r_level - LW'(1);
            end
         end
         // A fault in the same cycle as a clear must still leave the flag set.
         r_overflow  <= (r_overflow  && !i_clr_flags) || w_ovf_evt;
         r_underflow <= (r_underflow && !i_clr_flags) || w_unf_evt;
      end
   end

   assign o_pop_dat   = r_mem[w_rd_ptr];
   assign o_level     = r_level;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with GOTO/CALL/RET/SKIP/computed jump and a circular return stack.
// One update per enabled instruction cycle; pc/flush/level are registered (visible after the edge).
module pc_stack_unit
   import pc_pkg::*;
#(
   parameter int              PC_W         = 13,
   parameter int              TARGET_W     = 11,
   parameter int              STACK_DEPTH  = 8,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    en,
   input  logic [2:0]                              op,
   input  logic [TARGET_W-1:0]                     target,
   input  logic [PC_W-9:0]                         pclath,
   input  logic [7:0]                              pcl_data,
   input  logic                                    clr_flags,
   output logic [PC_W-1:0]                         pc,
   output logic                                    flush,
   output logic [stack_level_w(STACK_DEPTH)-1:0]   stack_level,
   output logic                                    stack_overflow,
   output logic                                    stack_underflow
);

   logic [PC_W-1:0] r_pc;
   logic            r_flush;

   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_goto_addr;
   logic [PC_W-1:0] w_ldpcl_addr;
   logic [PC_W-1:0] w_pop_dat;
   logic [PC_W-1:0] w_pc_next;
   logic            w_flush_next;
   logic            w_push;
   logic            w_pop;

   assign w_pc_inc     = r_pc + PC_W'(1);
   // Upper page bits come from PCLATH above the literal's reach.
   assign w_goto_addr  = {pclath[PC_W-9:TARGET_W-8], target};
   assign w_ldpcl_addr = {pclath, pcl_data};

   always_comb begin
      w_pc_next    = w_pc_inc;
      w_flush_next = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      case (op)
         OP_GOTO: begin
            w_pc_next    = w_goto_addr;
            w_flush_next = 1'b1;
         end
         OP_CALL: begin
            w_pc_next    = w_goto_addr;
            w_flush_next = 1'b1;
            w_push       = en;
         end
         OP_RET: begin
            w_pc_next    = w_pop_dat;
            w_flush_next = 1'b1;
            w_pop        = en;
         end
         OP_SKIP: begin
            w_flush_next = 1'b1;
         end
         OP_HOLD: begin
            w_pc_next    = r_pc;
         end
         OP_LDPCL: begin
            w_pc_next    = w_ldpcl_addr;
            w_flush_next = 1'b1;
         end
         default: begin
            w_pc_next    = w_pc_inc;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc    <= RESET_VECTOR;
         r_flush <= 1'b0;
      end else if (en) begin
         r_pc    <= w_pc_next;
         r_flush <= w_flush_next;
      end
   end

   hw_stack #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_hw_stack (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_dat  (w_pc_inc),
      .i_clr_flags (clr_flags),
      .o_pop_dat   (w_pop_dat),
      .o_level     (stack_level),
      .o_overflow  (stack_overflow),
      .o_underflow (stack_underflow)
   );

   assign pc    = r_pc;
   assign flush = r_flush;

endmodule
